// File: rtl/fractal_sync_rf_sched.sv
// Round-robin request scheduler for one fractal-sync RF lookup port.
// Bypassed lookups are parked in a retry FIFO, and that FIFO has strict priority over new grants.
module fractal_sync_rf_sched #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned LEVEL_WIDTH = 1,
   parameter int unsigned ID_WIDTH    = 1,
   parameter int unsigned SD_WIDTH    = 2,
   parameter int unsigned RETRY_DEPTH = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [N_REQ-1:0]                req_valid_i,
   output logic [N_REQ-1:0]                req_ready_o,
   input  logic [N_REQ*LEVEL_WIDTH-1:0]    req_level_i,
   input  logic [N_REQ*ID_WIDTH-1:0]       req_id_i,
   input  logic [N_REQ*SD_WIDTH-1:0]       req_sd_i,
   input  logic [N_REQ-1:0]                req_remote_i,
   output logic [LEVEL_WIDTH-1:0]          rf_level_o,
   output logic [ID_WIDTH-1:0]             rf_id_o,
   output logic [SD_WIDTH-1:0]             rf_sd_o,
   output logic                            rf_check_local_o,
   output logic                            rf_check_remote_o,
   input  logic                            rf_present_i,
   input  logic                            rf_bypass_i,
   input  logic                            rf_ignore_i,
   input  logic                            rf_err_i,
   input  logic [SD_WIDTH-1:0]             rf_sd_i,
   output logic                            rsp_valid_o,
   input  logic                            rsp_ready_i,
   output logic [$clog2(N_REQ)-1:0]        rsp_src_o,
   output logic                            rsp_present_o,
   output logic                            rsp_err_o,
   output logic [SD_WIDTH-1:0]             rsp_sd_o
);

   localparam int unsigned SRC_W = $clog2(N_REQ);
   localparam int unsigned PTR_W = (RETRY_DEPTH > 1) ? $clog2(RETRY_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [SRC_W-1:0]       src;
      logic [LEVEL_WIDTH-1:0] level;
      logic [ID_WIDTH-1:0]    id;
      logic [SD_WIDTH-1:0]    sd;
      logic                   remote;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   state_e              state_q;
   req_t                hold_q;
   req_t                fifo_q [RETRY_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [LEVEL_WIDTH-1:0] rf_level_q;
   logic [ID_WIDTH-1:0] rf_id_q;
   logic [SD_WIDTH-1:0] rf_sd_q;
   logic                rf_check_local_q, rf_check_remote_q;
   logic                rsp_valid_q, rsp_present_q, rsp_err_q;
   logic [SRC_W-1:0]    rsp_src_q;
   logic [SD_WIDTH-1:0] rsp_sd_q;

   logic                grant_vld, pop, take;
   logic [SRC_W-1:0]    grant_idx;
   req_t                grant_req, next_ent;
   int unsigned         idx;

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_req = '0;
      idx       = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % N_REQ;
         if (!grant_vld && req_valid_i[idx]) begin
            grant_vld        = 1'b1;
            grant_idx        = SRC_W'(idx);
            grant_req.src    = SRC_W'(idx);
            grant_req.level  = req_level_i[idx*LEVEL_WIDTH +: LEVEL_WIDTH];
            grant_req.id     = req_id_i[idx*ID_WIDTH +: ID_WIDTH];
            grant_req.sd     = req_sd_i[idx*SD_WIDTH +: SD_WIDTH];
            grant_req.remote = req_remote_i[idx];
         end
      end
   end

   // An empty FIFO is required for a grant, which also covers the full-FIFO block
   always_comb begin
      pop         = (state_q == IDLE) && (cnt_q != '0);
      take        = (state_q == IDLE) && (cnt_q == '0) && grant_vld;
      next_ent    = pop ? fifo_q[rd_ptr_q] : grant_req;
      rr_ptr_d    = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      req_ready_o = '0;
      if (take) req_ready_o[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         hold_q            <= '0;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         cnt_q             <= '0;
         rr_ptr_q          <= '0;
         rf_level_q        <= '0;
         rf_id_q           <= '0;
         rf_sd_q           <= '0;
         rf_check_local_q  <= 1'b0;
         rf_check_remote_q <= 1'b0;
         rsp_valid_q       <= 1'b0;
         rsp_src_q         <= '0;
         rsp_present_q     <= 1'b0;
         rsp_err_q         <= 1'b0;
         rsp_sd_q          <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop || take) begin
                  hold_q            <= next_ent;
                  rf_level_q        <= next_ent.level;
                  rf_id_q           <= next_ent.id;
                  rf_sd_q           <= next_ent.sd;
                  rf_check_local_q  <= !next_ent.remote;
                  rf_check_remote_q <= next_ent.remote;
                  state_q           <= ISSUE;
               end
               if (pop) begin
                  rd_ptr_q <= (rd_ptr_q == PTR_W'(RETRY_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                  cnt_q    <= cnt_q - CNT_W'(1);
               end
               if (take) rr_ptr_q <= rr_ptr_d;
            end
            ISSUE: begin
               rf_level_q        <= '0;
               rf_id_q           <= '0;
               rf_sd_q           <= '0;
               rf_check_local_q  <= 1'b0;
               rf_check_remote_q <= 1'b0;
               if (rf_err_i) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_src_q     <= hold_q.src;
                  rsp_present_q <= 1'b0;
                  rsp_err_q     <= 1'b1;
                  rsp_sd_q      <= '0;
                  state_q       <= RESP;
               end else if (rf_ignore_i) begin
                  state_q <= IDLE;
               end else if (rf_bypass_i) begin
                  fifo_q[wr_ptr_q] <= hold_q;
                  wr_ptr_q <= (wr_ptr_q == PTR_W'(RETRY_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                  cnt_q    <= cnt_q + CNT_W'(1);
                  state_q  <= IDLE;
               end else begin
                  rsp_valid_q   <= 1'b1;
                  rsp_src_q     <= hold_q.src;
                  rsp_present_q <= rf_present_i;
                  rsp_err_q     <= 1'b0;
                  rsp_sd_q      <= hold_q.remote ? '0 : rf_sd_i;
                  state_q       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_src_q     <= '0;
                  rsp_present_q <= 1'b0;
                  rsp_err_q     <= 1'b0;
                  rsp_sd_q      <= '0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rf_level_o        = rf_level_q;
   assign rf_id_o           = rf_id_q;
   assign rf_sd_o           = rf_sd_q;
   assign rf_check_local_o  = rf_check_local_q;
   assign rf_check_remote_o = rf_check_remote_q;
   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_src_o         = rsp_src_q;
   assign rsp_present_o     = rsp_present_q;
   assign rsp_err_o         = rsp_err_q;
   assign rsp_sd_o          = rsp_sd_q;

endmodule

// File: tb/tb_fractal_sync_rf_sched.sv
// Randomized bench for fractal_sync_rf_sched against a transaction-level model
// built from queues: a retry list, an in-lookup item and a pending response.
module tb_fractal_sync_rf_sched;

   localparam int N = 4, LW = 1, IW = 1, SW = 2, RD = 2;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [N-1:0]    req_valid_i, req_ready_o, req_remote_i;
   logic [N*LW-1:0] req_level_i;
   logic [N*IW-1:0] req_id_i;
   logic [N*SW-1:0] req_sd_i;
   logic [LW-1:0]   rf_level_o;
   logic [IW-1:0]   rf_id_o;
   logic [SW-1:0]   rf_sd_o, rf_sd_i, rsp_sd_o;
   logic            rf_check_local_o, rf_check_remote_o;
   logic            rf_present_i, rf_bypass_i, rf_ignore_i, rf_err_i;
   logic            rsp_valid_o, rsp_ready_i, rsp_present_o, rsp_err_o;
   logic [1:0]      rsp_src_o;

   always #5 clk = ~clk;

   fractal_sync_rf_sched #(
      .N_REQ(N), .LEVEL_WIDTH(LW), .ID_WIDTH(IW), .SD_WIDTH(SW), .RETRY_DEPTH(RD)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_level_i(req_level_i), .req_id_i(req_id_i), .req_sd_i(req_sd_i),
      .req_remote_i(req_remote_i),
      .rf_level_o(rf_level_o), .rf_id_o(rf_id_o), .rf_sd_o(rf_sd_o),
      .rf_check_local_o(rf_check_local_o), .rf_check_remote_o(rf_check_remote_o),
      .rf_present_i(rf_present_i), .rf_bypass_i(rf_bypass_i),
      .rf_ignore_i(rf_ignore_i), .rf_err_i(rf_err_i), .rf_sd_i(rf_sd_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_src_o(rsp_src_o),
      .rsp_present_o(rsp_present_o), .rsp_err_o(rsp_err_o), .rsp_sd_o(rsp_sd_o)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int src;
      int level;
      int id;
      int sd;
      bit remote;
   } txn_t;

   txn_t retry_q[$];
   txn_t look;
   bit   look_v;
   bit   rsp_v, rsp_pres, rsp_err;
   int   rsp_src, rsp_sd;
   int   rr;

   function automatic void model_reset();
      retry_q.delete();
      look_v = 0; rsp_v = 0; rr = 0;
      rsp_src = 0; rsp_pres = 0; rsp_err = 0; rsp_sd = 0;
   endfunction

   // One clock of the reference: check the outputs now, then advance to the next cycle
   task automatic step();
      logic [N-1:0] e_ready;
      txn_t nl;
      bit   nl_v;
      int   g;
      e_ready = '0;
      nl_v = 0;
      nl = '{0, 0, 0, 0, 1'b0};
      if (!look_v && !rsp_v) begin
         if (retry_q.size() > 0) begin
            nl = retry_q.pop_front();
            nl_v = 1;
         end else begin
            for (int k = 0; k < N; k++) begin
               g = (rr + k) % N;
               if (!nl_v && req_valid_i[g]) begin
                  e_ready[g] = 1'b1;
                  nl = '{g, int'(req_level_i[g*LW +: LW]), int'(req_id_i[g*IW +: IW]),
                         int'(req_sd_i[g*SW +: SW]), req_remote_i[g]};
                  nl_v = 1;
                  rr = (g + 1) % N;
               end
            end
         end
      end
      check("req_ready", 32'(req_ready_o), 32'(e_ready));
      check("chk_local", 32'(rf_check_local_o), 32'(look_v && !look.remote));
      check("chk_remote", 32'(rf_check_remote_o), 32'(look_v && look.remote));
      check("rf_level", 32'(rf_level_o), look_v ? look.level : 0);
      check("rf_id", 32'(rf_id_o), look_v ? look.id : 0);
      check("rf_sd", 32'(rf_sd_o), look_v ? look.sd : 0);
      check("rsp_valid", 32'(rsp_valid_o), 32'(rsp_v));
      check("rsp_src", 32'(rsp_src_o), rsp_v ? rsp_src : 0);
      check("rsp_present", 32'(rsp_present_o), 32'(rsp_v && rsp_pres));
      check("rsp_err", 32'(rsp_err_o), 32'(rsp_v && rsp_err));
      check("rsp_sd", 32'(rsp_sd_o), rsp_v ? rsp_sd : 0);
      if (rsp_v && rsp_ready_i) rsp_v = 0;
      if (look_v) begin
         if (rf_err_i) begin
            rsp_v = 1; rsp_src = look.src; rsp_pres = 0; rsp_err = 1; rsp_sd = 0;
         end else if (rf_ignore_i) begin
         end else if (rf_bypass_i) begin
            retry_q.push_back(look);
         end else begin
            rsp_v = 1; rsp_src = look.src; rsp_pres = rf_present_i; rsp_err = 0;
            rsp_sd = look.remote ? 0 : int'(rf_sd_i);
         end
      end
      look = nl;
      look_v = nl_v;
      if (rst_i) model_reset();
   endtask

   task automatic drive_random();
      rst_i        = ($urandom_range(0, 999) < 5);
      req_valid_i  = N'($urandom);
      req_remote_i = N'($urandom);
      req_level_i  = (N*LW)'($urandom);
      req_id_i     = (N*IW)'($urandom);
      req_sd_i     = (N*SW)'($urandom);
      rf_present_i = 1'($urandom);
      rf_sd_i      = SW'($urandom);
      rf_err_i     = ($urandom_range(0, 99) < 10);
      rf_ignore_i  = ($urandom_range(0, 99) < 15);
      rf_bypass_i  = ($urandom_range(0, 99) < 30);
      rsp_ready_i  = ($urandom_range(0, 99) < 70);
   endtask

   initial begin
      rst_i = 1'b1;
      req_valid_i = '0; req_remote_i = '0; req_level_i = '0; req_id_i = '0; req_sd_i = '0;
      rf_present_i = 0; rf_bypass_i = 0; rf_ignore_i = 0; rf_err_i = 0; rf_sd_i = '0;
      rsp_ready_i = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_ready", 32'(req_ready_o), 0);
      check("rst_chk", 32'({rf_check_local_o, rf_check_remote_o}), 0);
      check("rst_rf", 32'({rf_level_o, rf_id_o, rf_sd_o}), 0);
      check("rst_rsp", 32'({rsp_valid_o, rsp_src_o, rsp_present_o, rsp_err_o, rsp_sd_o}), 0);

      // Single local request from requester 2, RF returns present with sd=2'b10
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rst_i = 1'b0;
         req_valid_i = 4'b0100; req_remote_i = '0; req_level_i = '0;
         req_id_i = 4'b0100; req_sd_i = 8'b0001_0000;
         rf_present_i = 1; rf_sd_i = 2'b10; rf_err_i = 0; rf_ignore_i = 0; rf_bypass_i = 0;
         rsp_ready_i = 1;
         #1;
         if (c == 0) check("single_ready", 32'(req_ready_o), 32'h4);
         if (c == 1) check("single_strobe", 32'({rf_check_local_o, rf_id_o, rf_sd_o}), 32'b1_1_01);
         if (c == 2) check("single_rsp", 32'({rsp_valid_o, rsp_src_o, rsp_present_o, rsp_sd_o}), 32'b1_10_1_10);
         step();
      end

      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         drive_random();
         #1;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
